// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_OFF_N  = 7'h7F;

endpackage

// File: rtl/sevenseg_decoder.sv
// BCD to seven-segment decoder, active-high segments g..a; any non-decimal code is dark.
module sevenseg_decoder (
  input  logic [3:0] bcd,
  output logic [6:0] sevenseg
);

  always_comb begin
    sevenseg = 7'h00;
    case (bcd)
      4'h0:    sevenseg = 7'h3F;
      4'h1:    sevenseg = 7'h06;
      4'h2:    sevenseg = 7'h5B;
      4'h3:    sevenseg = 7'h4F;
      4'h4:    sevenseg = 7'h66;
      4'h5:    sevenseg = 7'h6D;
      4'h6:    sevenseg = 7'h7D;
      4'h7:    sevenseg = 7'h07;
      4'h8:    sevenseg = 7'h7F;
      4'h9:    sevenseg = 7'h6F;
      default: sevenseg = 7'h00;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller: snapshots a packed BCD word per frame and drives one
// common-anode digit at a time through a shared decoder, with blanking gaps and zero suppression.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned ON_CYCLES    = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    lzs_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done
);

  localparam int unsigned MAX_DWELL = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
  localparam int unsigned CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
  localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t               state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [4*NUM_DIGITS-1:0]   snap_digits, snap_digits_nxt;
  logic [NUM_DIGITS-1:0]     snap_dp, snap_dp_nxt;
  logic                      load;
  logic                      frame_done_nxt;
  logic [3:0]                nibble;
  logic                      upper_zero;
  logic                      blank;
  logic [3:0]                bcd_q, bcd_nxt;
  logic [6:0]                seg_dec;
  logic [6:0]                seg_n_nxt;
  logic                      dp_n_nxt;
  logic [NUM_DIGITS-1:0]     digit_sel_nxt;

  // Next-state, snapshot and next-output logic; outputs are built from next-state values
  // so the registered outputs line up with the state they describe.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cnt_nxt         = cnt;
    load            = 1'b0;
    frame_done_nxt  = 1'b0;
    snap_digits_nxt = snap_digits;
    snap_dp_nxt     = snap_dp;
    nibble          = 4'h0;
    upper_zero      = 1'b1;
    blank           = 1'b0;
    bcd_nxt         = BLANK_CODE;
    seg_n_nxt       = SEG_OFF_N;
    dp_n_nxt        = 1'b1;
    digit_sel_nxt   = '1;

    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          load      = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == ON_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == IDX_LAST) begin
              idx_nxt        = '0;
              frame_done_nxt = 1'b1;
              load           = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end

    if (load) begin
      snap_digits_nxt = digits;
      snap_dp_nxt     = dp;
    end

    // Leading-zero test looks at this digit and every more-significant one.
    nibble = snap_digits_nxt[{idx_nxt, 2'b00} +: 4];
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_nxt) && (snap_digits_nxt[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = ((nibble >= 4'hA) && (nibble != 4'hF)) ||
            (lzs_en && (idx_nxt != '0) && upper_zero);

    if (state_nxt != IDLE) begin
      bcd_nxt   = blank ? BLANK_CODE : nibble;
      seg_n_nxt = ~seg_dec;
    end
    if (state_nxt == SHOW) begin
      digit_sel_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
      dp_n_nxt      = ~snap_dp_nxt[idx_nxt];
    end
  end

  sevenseg_decoder u_dec (
    .bcd      (bcd_q),
    .sevenseg (seg_dec)
  );

  // FSM and snapshot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      snap_digits <= snap_digits_nxt;
      snap_dp     <= snap_dp_nxt;
    end
  end

  // Output registers; segments trail the nibble by one cycle, hidden by the blank gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q       <= BLANK_CODE;
      seg_n       <= SEG_OFF_N;
      dp_n        <= 1'b1;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
    end else begin
      bcd_q       <= bcd_nxt;
      seg_n       <= seg_n_nxt;
      dp_n        <= dp_n_nxt;
      digit_sel_n <= digit_sel_nxt;
      frame_done  <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: stimulus queues expected lit cycles and frame
// strobes, a negedge monitor pops and compares whenever an anode is on or frame_done fires.
module tb_sevenseg_scan_ctrl;

  localparam int ND    = 4;
  localparam int BC    = 2;
  localparam int OC    = 5;
  localparam int SLOT  = BC + OC;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] S0 = ~7'h3F;
  localparam logic [6:0] S1 = ~7'h06;
  localparam logic [6:0] S2 = ~7'h5B;
  localparam logic [6:0] S3 = ~7'h4F;
  localparam logic [6:0] S4 = ~7'h66;
  localparam logic [6:0] S5 = ~7'h6D;
  localparam logic [6:0] S7 = ~7'h07;
  localparam logic [6:0] S9 = ~7'h6F;
  localparam logic [6:0] SB = 7'h7F;

  typedef struct packed {
    int         cyc;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } lit_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          lzs_en;
  logic [15:0]   digits;
  logic [3:0]    dp;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [3:0]    digit_sel_n;
  logic          frame_done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  lit_t lit_q[$];
  int   fd_q[$];
  lit_t mon_e;
  int   k;
  int   k2;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .BLANK_CYCLES (BC),
    .ON_CYCLES    (OC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .lzs_en      (lzs_en),
    .digits      (digits),
    .dp          (dp),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .digit_sel_n (digit_sel_n),
    .frame_done  (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, exp);
    end
  endtask

  // Queue the lit cycles of one frame starting with BLANK entry at edge k0.
  task automatic push_frame(input int k0, input logic [27:0] segs, input logic [3:0] dpn,
                            input int nlit, input bit fd);
    lit_t e;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < OC; c++) begin
        if (d * OC + c < nlit) begin
          e.cyc = k0 + d * SLOT + BC + c;
          e.sel = ~(4'b0001 << d);
          e.seg = segs[7*d +: 7];
          e.dp  = dpn[d];
          lit_q.push_back(e);
        end
      end
    end
    if (fd) fd_q.push_back(k0 + FRAME);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_digit_sel_n"}, 32'(digit_sel_n), 32'hF);
    check({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
    check({tag, "_dp_n"}, 32'(dp_n), 32'h1);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Monitor: any lit anode or frame strobe must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (digit_sel_n !== 4'hF) begin
        if (lit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_lit at cycle %0d: digit_sel_n=%h seg_n=%h, required dark",
                   cyc, digit_sel_n, seg_n);
        end else begin
          mon_e = lit_q.pop_front();
          check("lit_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("digit_sel_n", 32'(digit_sel_n), 32'(mon_e.sel));
          check("seg_n", 32'(seg_n), 32'(mon_e.seg));
          check("dp_n", 32'(dp_n), 32'(mon_e.dp));
        end
      end
      if (frame_done !== 1'b0) begin
        if (fd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done at cycle %0d: got %b, required 0", cyc, frame_done);
        end else begin
          check("frame_done_cycle", 32'(cyc), 32'(fd_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    lzs_en = 1'b0;
    digits = 16'h1234;
    dp     = 4'b0100;
    repeat (3) @(negedge clk);
    check_dark("reset");
    mon_en = 1'b1;
    rst_n  = 1'b1;
    k      = cyc + 1;

    // Two frames of 1234; the second proves a mid-frame change does not tear it.
    push_frame(k,           {S1, S2, S3, S4}, 4'b1011, 20, 1'b1);
    push_frame(k + FRAME,   {S1, S2, S3, S4}, 4'b1011, 20, 1'b1);
    wait_until(k + 40);
    digits = 16'h9999;
    push_frame(k + 2*FRAME, {S9, S9, S9, S9}, 4'b1011, 20, 1'b1);

    wait_until(k + 60);
    digits = 16'h0070;
    dp     = 4'b0000;
    lzs_en = 1'b1;
    push_frame(k + 3*FRAME, {SB, SB, S7, S0}, 4'b1111, 20, 1'b1);

    wait_until(k + 4*FRAME);
    lzs_en = 1'b0;
    push_frame(k + 4*FRAME, {S0, S0, S7, S0}, 4'b1111, 20, 1'b1);

    wait_until(k + 120);
    digits = 16'hC5A0;
    push_frame(k + 5*FRAME, {SB, S5, SB, S0}, 4'b1111, 20, 1'b1);
    // Frame 7 is cut on the third lit cycle of digit 2: no strobe expected.
    push_frame(k + 6*FRAME, {SB, S5, SB, S0}, 4'b1111, 13, 1'b0);

    wait_until(k + 6*FRAME + 2*SLOT + BC + 2);
    en = 1'b0;
    wait_until(k + 6*FRAME + 2*SLOT + BC + 3);
    check_dark("disable");

    wait_until(k + 190);
    en = 1'b1;
    k2 = cyc + 1;
    push_frame(k2, {SB, S5, SB, S0}, 4'b1111, 20, 1'b1);
    wait_until(k2 + FRAME + 1);
    en = 1'b0;

    wait_until(k2 + FRAME + 6);
    check("lit_queue_drained", 32'(lit_q.size()), 32'h0);
    check("frame_done_queue_drained", 32'(fd_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexed scan controller that shares one `sevenseg_decoder` among the NUM_DIGITS common-anode digits of the digital-clock display. It snapshots a packed BCD word at every frame start and cycles through the digits, one at a time. For each digit it applies a blanking gap and then a fixed on-time. It also handles leading-zero suppression and invalid-code blanking, and emits a frame-done strobe. It sits between the timekeeping counters and the board pins.

## Interface
- `NUM_DIGITS`, 6, digit count (HH:MM:SS); must be ≥ 2.
- `BLANK_CYCLES`, 16, all-off cycles before each digit (anti-ghosting); must be ≥ 1.
- `ON_CYCLES`, 50000, cycles each digit is lit; must be ≥ 1.
- `clk  in  1`  system clock; every register updates on its rising edge.
- `rst_n  in  1`  reset, synchronous and active-low.
- `en  in  1`  scanning enable. When low, the display is dark.
- `lzs_en  in  1`  leading-zero suppression enable.
- `digits  in  4*NUM_DIGITS`  packed BCD. Digit i is `digits[4i+3:4i]`; digit 0 is the rightmost.
- `dp  in  NUM_DIGITS`  decimal point request per digit, active-high.
- `seg_n  out  7`  segments g..a, active-low. This is the inverse of the decoder's `sevenseg`.
- `dp_n  out  1`  decimal point, active-low.
- `digit_sel_n  out  NUM_DIGITS`  anode select, active-low, one-cold while a digit is lit.
- `frame_done  out  1`  one-cycle pulse at the end of each complete frame.

## Operation
- States: `IDLE`, `BLANK`, `SHOW`. `idx` is the current digit, range 0..NUM_DIGITS-1. `cnt` is the dwell counter.
- Reset, or `en`=0 in any state: next state is `IDLE`, with `idx`=0 and `cnt`=0.
- Outputs in `IDLE`:
  - `digit_sel_n` = all 1.
  - `seg_n` = 7'h7F.
  - `dp_n` = 1.
  - `frame_done` = 0.
- `IDLE` → `BLANK` on the first clock with `en`=1. On that edge, `digits` and `dp` are captured into the snapshot.
- `BLANK`:
  - Anodes are all off.
  - `bcd` to the decoder is already the code for digit `idx`, so the segments settle before the anode turns on.
  - Stays for BLANK_CYCLES cycles, then moves to `SHOW`.
- `SHOW`:
  - `digit_sel_n[idx]` = 0 and all other anode bits = 1.
  - `dp_n` = ~snapshot `dp[idx]`.
  - Stays for ON_CYCLES cycles.
- `SHOW` exit when `idx` < NUM_DIGITS-1: `idx`+1, then `BLANK`.
- `SHOW` exit when `idx` = NUM_DIGITS-1: `idx` = 0, `frame_done` = 1 for one cycle, a new snapshot is taken, then `BLANK`.
- The snapshot changes only at frame boundaries. A mid-frame change on `digits` never tears the frame.
- Blanking: the nibble sent to the decoder is forced to `BLANK_CODE` (4'hF), which decodes to all segments off. This happens when:
  - the snapshot nibble is 4'hA..4'hE (invalid BCD), or
  - `lzs_en`=1, `idx` > 0, and snapshot digits `idx`..NUM_DIGITS-1 are all 0.
- Digit 0 is never suppressed.
- On a blanked digit, the anode and `dp_n` behave normally.
- `lzs_en` is sampled live every cycle; it is not part of the snapshot.
- Simultaneous events: a falling `en` takes priority over an end-of-dwell transition. `frame_done` is not pulsed in that case.

## Timing
- All outputs are registered. The outputs for state S appear on the cycle after the edge that entered S.
- One digit slot is BLANK_CYCLES + ON_CYCLES cycles. One frame is NUM_DIGITS × (BLANK_CYCLES + ON_CYCLES) cycles.
- First lit anode: `en` rises at edge k, so the `BLANK` outputs appear after edge k. The first `SHOW` outputs appear after edge k+BLANK_CYCLES.
- `frame_done` is high in the cycle after the final `SHOW` cycle of digit NUM_DIGITS-1, which is the first cycle of the next `BLANK`.
- `cnt` width = $clog2(max(BLANK_CYCLES, ON_CYCLES)). `idx` width = $clog2(NUM_DIGITS). `cnt` compares against PARAM-1, so there is no terminal-count overflow.

## Structure
- `sevenseg_pkg`:
  - state enum `scan_state_t` {`IDLE`, `BLANK`, `SHOW`},
  - `BLANK_CODE` = 4'hF,
  - `SEG_OFF_N` = 7'h7F.
- Sub-module: one instance of the existing `sevenseg_decoder` (combinational). It is fed by the registered, masked nibble. Its `sevenseg` output is inverted and registered into `seg_n`.

## Test plan
Bench parameters: NUM_DIGITS=4, BLANK_CYCLES=2, ON_CYCLES=5, so one frame is 28 cycles.
- Reset: hold `rst_n`=0 for 3 cycles with `en`=1 → `digit_sel_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1, `frame_done`=0.
- Basic scan: `digits`=16'h1234, `dp`=4'b0100.
  - After the 2-cycle blank, digit 0 shows `seg_n`=~7'b1100110 for 5 cycles.
  - Next, digit 1 shows ~7'b1001111, digit 2 shows ~7'b1011011 with `dp_n`=0, and digit 3 shows ~7'b0000110.
  - `frame_done` pulses once every 28 cycles.
- Tear-free update: change `digits` to 16'h9999 mid-frame → the current frame still shows 1234, and the next frame shows 9.
- LZS: `digits`=16'h0070, `lzs_en`=1 → digits 3 and 2 give `seg_n`=7'h7F with their anodes still pulsed. Digit 1 shows 7 and digit 0 shows 0. With `lzs_en`=0, all four digits are lit.
- Invalid code: `digits`=16'hC5A0 → digits 3 and 1 are blank (7'h7F), digit 2 shows 5, digit 0 shows 0.
- Disable mid-digit: drop `en` on cycle 3 of digit 2's `SHOW` → outputs are off on the next cycle with no `frame_done`. When `en` is re-raised, scanning restarts at digit 0 after a 2-cycle blank.
